rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//   8-requester round-robin arbiter for one shared resource.
//   Issues a registered one-hot grant plus its 3-bit binary index and a valid flag.
//   Downstream logic uses the index to steer the shared datapath.
//   Sits between the requesting agents and the shared unit; holds a grant until the owner drops its request.
// PARAMETERS
//   N_REQ     8    number of requesters; fixed at 8, index width 3
//   MAX_HOLD  16   max consecutive grant cycles (used only with RR_ARB_TIMEOUT_EN); legal range 2..255
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset, sampled on clk
//   en         in   1  arbiter enable; when low, no grant is issued
//   req        in   8  request vector; bit i = requester i; held high while the resource is wanted
//   grant      out  8  one-hot grant (registered); all-zero when nothing is granted
//   grant_idx  out  3  binary index of the set grant bit; 3'd0 when grant_vld=0
//   grant_vld  out  1  high while grant is non-zero
//   timeout    out  1  one-cycle pulse on a forced release; tied 0 when the feature is compiled out
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): grant=0, grant_idx=0, grant_vld=0, timeout=0, ptr=0, state=IDLE.
//     Reset takes effect mid-grant the same way, with no completion cycle.
//   ptr[2:0] marks the highest-priority requester. Search order is ptr, ptr+1, ... wrapping mod 8.
//   State machine:
//     IDLE:
//       If en=1 and req!=0, pick the first set bit at or after ptr.
//       Next cycle: grant=onehot(w), grant_idx=w, grant_vld=1, state=GRANT.
//       Grant latency from req rising is 1 clk.
//     GRANT:
//       Hold grant while en=1 and req[grant_idx]=1.
//       Other requests are ignored while the grant is held.
//     RELEASE (entered when req[grant_idx]=0 or en=0):
//       Clear grant, grant_idx and grant_vld on that clk edge.
//       Set ptr = grant_idx+1 (7 wraps to 0).
//       Return to IDLE.
//   There is always at least 1 IDLE cycle between consecutive grants, with no back-to-back handover.
//   Simultaneous requests: the winner is the nearest at or after ptr. A requester absent at sample time waits its turn.
//   en low in IDLE: stay in IDLE and leave ptr unchanged.
//   en low in GRANT: grant is revoked on the next edge, as a normal release with ptr advance.
//   A requester that drops req before its grant appears still receives the grant for exactly 1 cycle, then is released.
//   Invariant: popcount(grant) <= 1 and grant_vld == |grant at all times.
// CONFIGURATION
//   Macro RR_ARB_TIMEOUT_EN.
//   Defined:
//     An 8-bit hold counter clears on grant entry and increments each GRANT cycle.
//     When the counter reaches MAX_HOLD-1 while still held, the grant is force-released on the next edge.
//     timeout=1 for that single cycle and ptr advances past the offender.
//     An owner that still requests re-enters arbitration with lowest priority.
//   Not defined:
//     No counter exists and timeout is a constant 0.
//     A grant is held indefinitely while req stays high.
// STRUCTURE
//   Package rr_arb_pkg holds:
//     N_REQ=8 and IDX_W=3;
//     typedef enum {ARB_IDLE, ARB_GRANT} arb_state_t;
//     typedef logic [IDX_W-1:0] arb_idx_t.
//   Sub-module rr_pick8: combinational rotate-by-ptr plus priority search.
//     Inputs req and ptr; outputs win_idx and win_vld.
//   The top level is the FSM, the registers and the optional hold counter.
// TESTING
//   1. Reset then req=8'h00 -> grant=0, grant_vld=0, grant_idx=0 for 10 cycles.
//   2. req=8'h81 with ptr=0 ->
//        grant=8'h01 (idx 0);
//        drop req[0] -> 1 idle cycle -> grant=8'h80 (idx 7);
//        drop req[7] -> ptr=0 -> next grant goes to 0.
//   3. req=8'hFF held, each owner drops its request after 3 cycles ->
//        grants in order 0,1,...,7,0;
//        each grant lasts 3 cycles, followed by 1 idle cycle.
//   4. Grant active on idx 3, en forced to 0 ->
//        grant=0 on the next edge, with no new grant while en=0;
//        en=1 with req=8'h08 -> regrant to idx 3 only after the idle cycle.
//   5. rst_n=0 for 1 cycle mid-grant on idx 5 ->
//        all outputs cleared on that edge;
//        ptr=0, so req=8'h21 grants idx 0 first.
//   6. With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, req=8'h03 held ->
//        idx0 holds for 4 cycles, then timeout pulses 1 cycle;
//        idx1 is granted next.
//      Without the macro: idx0 is held forever and timeout stays 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the 8-way round-robin arbiter
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input arb_idx_t idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - rotate-by-ptr priority search returning the first requester at or after ptr
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  arb_idx_t         ptr,
  output arb_idx_t         win_idx,
  output logic             win_vld
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  arb_idx_t           off;

  // Doubling the vector lets a plain part-select perform the rotation.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  always_comb begin
    off     = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off     = arb_idx_t'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign win_idx = ptr + off;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter, grant held until owner drops req
// Optional hold-limit with forced release: RR_ARB_TIMEOUT_EN
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output arb_idx_t         grant_idx,
  output logic             grant_vld,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state_q;
  arb_idx_t         ptr_q;
  logic [N_REQ-1:0] grant_q;
  arb_idx_t         idx_q;
  logic             vld_q;

  arb_idx_t win_idx;
  logic     win_vld;
  logic     owner_drop;
  logic     force_rel;
  logic     release_now;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign owner_drop  = !en || !req[idx_q];
  assign release_now = owner_drop || force_rel;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q;
  logic       timeout_q;

  assign force_rel = (hold_q == HOLD_LAST);

  // A voluntary release wins over a coincident limit hit, so no pulse then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == ARB_GRANT) && !owner_drop && force_rel;
      if (state_q == ARB_IDLE) begin
        hold_q <= '0;
      end else if (!release_now) begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (en && win_vld) begin
            grant_q <= idx_to_onehot(win_idx);
            idx_q   <= win_idx;
            vld_q   <= 1'b1;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= idx_q + arb_idx_t'(1);
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and randomized checks of rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  // Model: current owner (-1 = none), priority pointer, hold length, pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_hold  = 0;
          end
        end
      end
    end else if (!en || !req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b0;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
`else
      m_to = 1'b0;
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check_eq("grant_idx", grant_idx, (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_eq("grant_vld", grant_vld, (m_owner >= 0) ? 32'd1 : 32'd0);
    check_eq("timeout", timeout, m_to);
    check_eq("onehot_inv", ($countones(grant) <= 1 && grant_vld == |grant) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;

    // Idle after reset.
    do_reset();
    en = 1'b1;
    repeat (10) step();
    check_eq("t1_grant", grant, 32'h0);

    // Two requesters at the ends of the ring.
    do_reset();
    req = 8'h81;
    step();
    check_eq("t2_first", grant, 32'h01);
    step();
    req = 8'h80;
    step();
    check_eq("t2_gap", grant_vld, 32'd0);
    step();
    check_eq("t2_second", grant, 32'h80);
    check_eq("t2_second_idx", grant_idx, 32'd7);
    req = 8'h00;
    step();
    req = 8'h81;
    step();
    check_eq("t2_wrap", grant, 32'h01);

    // Everyone requesting, each owner leaves after 3 cycles.
    do_reset();
    req = 8'hFF;
    step();
    for (int g = 0; g < 9; g++) begin
      check_eq("t3_idx", grant_idx, 32'(g % 8));
      step();
      step();
      check_eq("t3_hold", grant_vld, 32'd1);
      req[g % 8] = 1'b0;
      step();
      check_eq("t3_gap", grant_vld, 32'd0);
      req = 8'hFF;
      step();
    end

    // Enable revoked mid-grant.
    do_reset();
    req = 8'h08;
    step();
    check_eq("t4_grant", grant_idx, 32'd3);
    step();
    en = 1'b0;
    step();
    check_eq("t4_revoke", grant, 32'h0);
    step();
    check_eq("t4_held_off", grant, 32'h0);
    en = 1'b1;
    step();
    check_eq("t4_regrant", grant, 32'h08);

    // Reset in the middle of a grant.
    do_reset();
    req = 8'h20;
    step();
    check_eq("t5_grant", grant_idx, 32'd5);
    step();
    rst_n = 1'b0;
    step();
    check_eq("t5_cleared", {grant, 5'd0, grant_idx, 7'd0, grant_vld, 7'd0, timeout}, 32'h0);
    rst_n = 1'b1;
    req = 8'h21;
    step();
    check_eq("t5_ptr0", grant, 32'h01);

    // Long hold by two requesters: forced release only when the limit is compiled in.
    do_reset();
    req = 8'h03;
    repeat (20) step();

    // Randomized traffic with occasional resets and enable drops.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = req & 8'($urandom);
        2: req = req | (8'd1 << $urandom_range(0, 7));
        default: req = req;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
